// File: rtl/f_result_buffer.sv
// f_result_buffer: in-order result FIFO behind the non-stallable FPU arithmetic
// wrappers. It captures every produced {error, result} pair and presents it on a
// valid/ready interface. It also counts operations in flight so that upstream
// only issues work the FIFO is guaranteed to absorb.
module f_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1),
    // Matches the global FLEN of the FPU configuration (double precision).
    parameter int FLEN  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_allowed,
    input  logic [FLEN-1:0]  arith_res,
    input  logic             arith_down_valid,
    input  logic             arith_error,
    output logic [FLEN-1:0]  res_data,
    output logic             res_error,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] inflight,
    output logic             protocol_error
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    // Each entry holds the error flag above the result bits.
    logic [FLEN:0]      mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   inflight_q;
    logic               perr_q;

    logic               full;
    logic               pop;
    logic               push;
    logic               issue_acc;
    logic               returned;
    logic               violation;
    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   inflight_next;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign count          = count_q;
    assign inflight       = inflight_q;
    assign protocol_error = perr_q;
    assign res_valid      = (count_q != '0);
    assign res_data       = mem[head][FLEN-1:0];
    assign res_error      = mem[head][FLEN];

    // Handshake decode and next-state for the occupancy/in-flight counters.
    always_comb begin
        full          = (count_q == DEPTH_CNT);
        pop           = res_valid && res_ready;
        // A full FIFO still accepts a result when the head leaves the same cycle.
        push          = arith_down_valid && (!full || pop);
        // Registered state only; independent of issue_valid.
        issue_allowed = !rst && (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_EXT);
        issue_acc     = issue_valid && issue_allowed;
        returned      = arith_down_valid && (inflight_q != '0);
        violation     = (issue_valid && !issue_allowed)
                     || (arith_down_valid && (inflight_q == '0))
                     || (arith_down_valid && full && !pop);

        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase

        inflight_next = inflight_q;
        case ({issue_acc, returned})
            2'b10:   inflight_next = inflight_q + CNT_W'(1);
            2'b01:   inflight_next = inflight_q - CNT_W'(1);
            default: inflight_next = inflight_q;
        endcase
    end

    // Control state: pointers, counters and the sticky violation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            count_q    <= count_next;
            inflight_q <= inflight_next;
            if (violation) perr_q <= 1'b1;
        end
    end

    // Entry storage; not reset, contents are only observed while res_valid=1.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[tail] <= {arith_error, arith_res};
    end

endmodule
